muldiv_sequencer: RTL and testbench
===================================

MULDIV_SEQUENCER -- requirements
Module: muldiv_sequencer

Interface
REQ-001 Parameter: XLEN, default 32, operand/result width; shall be fixed at 32 for rvsimple.
REQ-002 The block SHALL have the following ports, one per line (name  direction  width  meaning):
- clock  in  1  single clock; all state updates on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  request present.
- in_ready  out  1  block can accept a request.
- funct3  in  3  M-extension op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- operand_a  in  XLEN  rs1 value (multiplicand/dividend).
- operand_b  in  XLEN  rs2 value (multiplier/divisor).
- flush  in  1  pipeline kill; aborts any operation.
- out_valid  out  1  result available.
- out_ready  in  1  consumer takes the result.
- result  out  XLEN  operation result.
- busy  out  1  state != IDLE.

Function
REQ-003 States: IDLE, CALC, FIX, DONE; one state register, binary encoded.
REQ-004 in_ready SHALL be 1 only in IDLE with flush=0.
REQ-005 A request SHALL be accepted on the edge where in_valid & in_ready; funct3 and operands are latched then, and later input changes are ignored.
REQ-006 On accept, a special case (DIV/DIVU/REM/REMU with operand_b=0, or DIV/REM with operand_a=0x80000000 and operand_b=0xFFFFFFFF) SHALL go IDLE->DONE; every other op SHALL go IDLE->CALC.
REQ-007 On accept, signed ops SHALL latch operand magnitudes, with the result sign recorded:
- MULH: both signed.
- MULHSU: a signed, b unsigned.
- DIV/REM: both signed.
REQ-008 CALC SHALL run exactly XLEN cycles, driven by a 5-bit iteration counter loaded with XLEN-1 and decremented each cycle; at count 0 it goes CALC->FIX.
REQ-009 Multiply iteration: shift-add on a 2*XLEN-bit accumulator, one multiplier bit per cycle, LSB first.
REQ-010 Divide iteration: restoring division, one quotient bit per cycle, MSB first, using an XLEN+1-bit partial remainder.
REQ-011 FIX SHALL last one cycle, then go FIX->DONE, and SHALL select the result:
- MUL: low XLEN bits.
- MULH/MULHSU/MULHU: high XLEN bits.
- DIV/DIVU: quotient.
- REM/REMU: remainder.
- Signed ops: two's-complement negation of the full 2*XLEN product, quotient, or remainder where required.
- Remainder sign SHALL follow the dividend.
REQ-012 Special-case results:
- Divide by zero: quotient=0xFFFFFFFF, remainder=operand_a.
- Signed overflow: quotient=0x80000000, remainder=0.
REQ-013 DONE SHALL drive out_valid=1 with result stable until out_ready=1; that edge goes DONE->IDLE.
REQ-014 Latency SHALL be XLEN+2 cycles from accept edge to out_valid for normal ops (34 at XLEN=32), and 1 cycle for special cases.
REQ-015 out_valid may stall indefinitely; no result may be lost or altered while out_ready=0.
REQ-016 flush=1 in any state SHALL force IDLE on the next edge, clear out_valid, and discard the operation; flush has priority over out_ready and in_valid.
REQ-017 A new request may be accepted on the first IDLE cycle after DONE (no back-to-back accept in the DONE cycle).
REQ-018 result SHALL be 0 whenever out_valid=0.

Reset
REQ-019 reset_n=0 SHALL asynchronously force:
- state=IDLE, counter=0, accumulators=0.
- out_valid=0, result=0, busy=0.
- in_ready=1 after release, when flush=0.
REQ-020 Assertion of reset_n mid-CALC or in DONE SHALL abort the operation with no out_valid pulse after release.

Verification
REQ-021 MUL a=7, b=0xFFFFFFFD -> result 0xFFFFFFEB, out_valid exactly 34 cycles after accept.
REQ-022 MULHU a=b=0xFFFFFFFF -> 0xFFFFFFFE; MULH same operands -> 0x00000000; MULHSU a=0xFFFFFFFF, b=2 -> 0xFFFFFFFF.
REQ-023 DIV a=0xFFFFFFF9 (-7), b=2 -> 0xFFFFFFFD; REM same -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU -> 2.
REQ-024 DIVU a=5, b=0 -> 0xFFFFFFFF; REM a=5, b=0 -> 5; DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; each with out_valid 1 cycle after accept.
REQ-025 Hold out_ready=0 for 10 cycles in DONE -> result and out_valid stable, in_ready=0; then raise out_ready -> IDLE next cycle, in_ready=1.
REQ-026 flush at CALC cycle 10, and separately reset_n pulse at CALC cycle 20 -> IDLE next edge (async for reset), no out_valid; next MUL 3*4 returns 12.

Source files
------------

// File: rtl/muldiv_sequencer.sv
// Iterative RV32M multiply/divide unit: one shift-add or restoring-divide step per cycle,
// 34-cycle latency for normal ops, single-cycle answers for divide-by-zero and signed overflow.
module muldiv_sequencer #(
  parameter int XLEN = 32
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] operand_a,
  input  logic [XLEN-1:0] operand_b,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);
  localparam int CW = $clog2(XLEN);

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t            r_state;
  logic [CW-1:0]     r_cnt;
  logic [2:0]        r_op;
  logic [XLEN-1:0]   r_b;
  logic [2*XLEN-1:0] r_acc;   // mul: {partial product, multiplier}; div: low half = dividend/quotient
  logic [XLEN-1:0]   r_rem;
  logic              r_neg_q;
  logic              r_neg_r;
  logic              r_out_valid;
  logic [XLEN-1:0]   r_result;

  // Operand conditioning at accept
  logic            w_sgn_a, w_sgn_b, w_a_neg, w_b_neg;
  logic [XLEN-1:0] w_a_mag, w_b_mag;
  logic            w_div0, w_ovf, w_special;
  logic [XLEN-1:0] w_spec_res;

  assign w_sgn_a = (funct3 == OP_MULH) || (funct3 == OP_MULHSU) ||
                   (funct3 == OP_DIV)  || (funct3 == OP_REM);
  assign w_sgn_b = (funct3 == OP_MULH) || (funct3 == OP_DIV) || (funct3 == OP_REM);
  assign w_a_neg = w_sgn_a & operand_a[XLEN-1];
  assign w_b_neg = w_sgn_b & operand_b[XLEN-1];
  assign w_a_mag = w_a_neg ? ({XLEN{1'b0}} - operand_a) : operand_a;
  assign w_b_mag = w_b_neg ? ({XLEN{1'b0}} - operand_b) : operand_b;

  assign w_div0    = funct3[2] && (operand_b == '0);
  assign w_ovf     = ((funct3 == OP_DIV) || (funct3 == OP_REM)) &&
                     (operand_a == {1'b1, {(XLEN-1){1'b0}}}) && (operand_b == '1);
  assign w_special = w_div0 | w_ovf;
  assign w_spec_res = w_div0 ? (funct3[1] ? operand_a : '1)
                             : (funct3[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}});

  // Iteration datapath
  logic [XLEN:0]   w_mul_sum;
  logic [XLEN:0]   w_shift;
  logic [XLEN+1:0] w_diff;
  logic            w_qbit;
  logic            w_unused;

  assign w_mul_sum = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_b} : '0);
  assign w_shift   = {r_rem, r_acc[XLEN-1]};
  assign w_diff    = {1'b0, w_shift} - {2'b00, r_b};
  assign w_qbit    = ~w_diff[XLEN+1];
  assign w_unused  = w_diff[XLEN];

  // Sign fix-up and result selection
  logic [2*XLEN-1:0] w_prod;
  logic [XLEN-1:0]   w_quo, w_remv, w_fix_res;

  assign w_prod = r_neg_q ? ({(2*XLEN){1'b0}} - r_acc) : r_acc;
  assign w_quo  = r_neg_q ? ({XLEN{1'b0}} - r_acc[XLEN-1:0]) : r_acc[XLEN-1:0];
  assign w_remv = r_neg_r ? ({XLEN{1'b0}} - r_rem) : r_rem;

  always_comb begin
    w_fix_res = '0;
    case (r_op)
      OP_MUL:                        w_fix_res = w_prod[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU:  w_fix_res = w_prod[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:               w_fix_res = w_quo;
      OP_REM, OP_REMU:               w_fix_res = w_remv;
      default:                       w_fix_res = '0;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_op        <= '0;
      r_b         <= '0;
      r_acc       <= '0;
      r_rem       <= '0;
      r_neg_q     <= 1'b0;
      r_neg_r     <= 1'b0;
      r_out_valid <= 1'b0;
      r_result    <= '0;
    end else if (flush) begin
      r_state     <= IDLE;
      r_out_valid <= 1'b0;
      r_result    <= '0;
    end else begin
      case (r_state)
        IDLE: if (in_valid) begin
          r_op    <= funct3;
          r_b     <= w_b_mag;
          r_acc   <= {{XLEN{1'b0}}, w_a_mag};
          r_rem   <= '0;
          r_neg_q <= w_a_neg ^ w_b_neg;
          r_neg_r <= w_a_neg;
          if (w_special) begin
            r_state     <= DONE;
            r_out_valid <= 1'b1;
            r_result    <= w_spec_res;
          end else begin
            r_state <= CALC;
            r_cnt   <= CW'(XLEN-1);
          end
        end
        CALC: begin
          if (r_op[2]) begin
            r_rem              <= w_qbit ? w_diff[XLEN-1:0] : w_shift[XLEN-1:0];
            r_acc[XLEN-1:0]    <= {r_acc[XLEN-2:0], w_qbit};
          end else begin
            r_acc <= {w_mul_sum, r_acc[XLEN-1:1]};
          end
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == '0) r_state <= FIX;
        end
        FIX: begin
          r_state     <= DONE;
          r_out_valid <= 1'b1;
          r_result    <= w_fix_res;
        end
        DONE: if (out_ready) begin
          r_state     <= IDLE;
          r_out_valid <= 1'b0;
          r_result    <= '0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == IDLE) & ~flush;
  assign busy      = (r_state != IDLE);
  assign out_valid = r_out_valid;
  assign result    = r_result;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer: vector table of ops with expected results and latency,
// plus hand-written stall, flush and mid-operation reset sequences.
module tb_muldiv_sequencer;
  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  funct3 = '0;
  logic [31:0] operand_a = '0;
  logic [31:0] operand_b = '0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] result;
  logic        busy;

  int n_pass = 0;
  int n_total = 0;

  muldiv_sequencer #(.XLEN(32)) dut (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .funct3(funct3), .operand_a(operand_a), .operand_b(operand_b), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .busy(busy)
  );

  always #5 clock = ~clock;

  typedef struct {
    string       name;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else n_pass++;
  endtask

  // Issue one request, scramble the inputs after the accept edge, and wait for out_valid.
  task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input logic ordy, output int lat);
    @(negedge clock);
    in_valid = 1'b1; funct3 = f3; operand_a = a; operand_b = b; out_ready = ordy;
    @(posedge clock);
    #1;
    in_valid = 1'b0; funct3 = ~f3; operand_a = 32'h1234_5678; operand_b = 32'h0000_0000;
    lat = 1;
    while (lat < 100) begin
      @(negedge clock);
      if (out_valid) break;
      @(posedge clock);
      lat++;
    end
  endtask

  task automatic no_valid_for(input string name, input int cycles);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clock);
      if (out_valid) seen = 1'b1;
    end
    chk(name, {31'd0, seen}, 32'd0);
  endtask

  initial begin
    int lat;

    vecs.push_back('{"MUL_7xm3",       3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 34});
    vecs.push_back('{"MULHU_max",      3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 34});
    vecs.push_back('{"MULH_m1m1",      3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 34});
    vecs.push_back('{"MULHSU_m1x2",    3'b010, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 34});
    vecs.push_back('{"MULH_min_min",   3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 34});
    vecs.push_back('{"MULHSU_min_max", 3'b010, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 34});
    vecs.push_back('{"DIV_m7_2",       3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 34});
    vecs.push_back('{"REM_m7_2",       3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 34});
    vecs.push_back('{"DIV_7_m2",       3'b100, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 34});
    vecs.push_back('{"REM_7_m2",       3'b110, 32'd7,        32'hFFFFFFFE, 32'h00000001, 34});
    vecs.push_back('{"DIV_m7_m2",      3'b100, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'h00000003, 34});
    vecs.push_back('{"DIVU_100_7",     3'b101, 32'd100,      32'd7,        32'd14,       34});
    vecs.push_back('{"REMU_100_7",     3'b111, 32'd100,      32'd7,        32'd2,        34});
    vecs.push_back('{"DIVU_max_1",     3'b101, 32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, 34});
    vecs.push_back('{"DIVU_div0",      3'b101, 32'd5,        32'd0,        32'hFFFFFFFF, 1});
    vecs.push_back('{"REM_div0",       3'b110, 32'd5,        32'd0,        32'd5,        1});
    vecs.push_back('{"DIV_ovf",        3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1});
    vecs.push_back('{"REM_ovf",        3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1});

    // Reset state
    #12;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    reset_n = 1'b1;
    @(negedge clock);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

    foreach (vecs[i]) begin
      run_op(vecs[i].f3, vecs[i].a, vecs[i].b, 1'b1, lat);
      chk({vecs[i].name, "_result"}, result, vecs[i].exp);
      chk({vecs[i].name, "_latency"}, lat, vecs[i].lat);
      @(posedge clock);
      @(negedge clock);
      chk({vecs[i].name, "_idle"}, {29'd0, in_ready, out_valid, busy}, 32'b100);
      chk({vecs[i].name, "_result_zero"}, result, 32'd0);
    end

    // Stall in DONE for 10 cycles
    run_op(3'b000, 32'd3, 32'd5, 1'b0, lat);
    chk("stall_latency", lat, 34);
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      chk("stall_hold", {in_ready, out_valid, result[29:0]}, {1'b0, 1'b1, 30'd15});
    end
    out_ready = 1'b1;
    @(posedge clock);
    @(negedge clock);
    chk("stall_release", {29'd0, in_ready, out_valid, busy}, 32'b100);

    // Flush in CALC cycle 10
    @(negedge clock);
    in_valid = 1'b1; funct3 = 3'b000; operand_a = 32'd9; operand_b = 32'd9;
    @(posedge clock);
    #1 in_valid = 1'b0;
    repeat (9) @(posedge clock);
    @(negedge clock);
    chk("calc_busy", {30'd0, busy, in_ready}, 32'b10);
    flush = 1'b1;
    #1 chk("flush_in_ready", {31'd0, in_ready}, 32'd0);
    @(posedge clock);
    #1 flush = 1'b0;
    @(negedge clock);
    chk("flush_idle", {30'd0, busy, in_ready}, 32'b01);
    no_valid_for("flush_no_valid", 40);

    // Flush while a result is waiting in DONE
    run_op(3'b101, 32'd5, 32'd0, 1'b0, lat);
    chk("flush_done_pre", {31'd0, out_valid}, 32'd1);
    flush = 1'b1;
    @(posedge clock);
    #1 flush = 1'b0;
    @(negedge clock);
    chk("flush_done_post", {29'd0, out_valid, busy, in_ready}, 32'b001);
    chk("flush_done_result", result, 32'd0);
    out_ready = 1'b1;

    // Asynchronous reset in CALC cycle 20
    @(negedge clock);
    in_valid = 1'b1; funct3 = 3'b100; operand_a = 32'd1000; operand_b = 32'd3;
    @(posedge clock);
    #1 in_valid = 1'b0;
    repeat (19) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b0;
    #1 chk("rst_async_busy", {30'd0, busy, out_valid}, 32'd0);
    #2 reset_n = 1'b1;
    no_valid_for("rst_no_valid", 40);

    run_op(3'b000, 32'd3, 32'd4, 1'b1, lat);
    chk("post_abort_mul", result, 32'd12);
    chk("post_abort_latency", lat, 34);
    @(posedge clock);
    @(negedge clock);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
